// File: rtl/refresh_scheduler.sv
// Per-bank refresh scheduler: a tREFI timer accrues refresh debt, and each debt unit is paid
// by a bg-major sweep of refresh requests over every bank, with tRFC blackout and tRRD spacing.
module refresh_scheduler #(
  parameter int BGWIDTH     = 2,
  parameter int BAWIDTH     = 2,
  parameter int TREFI       = 5200,
  parameter int TRFC        = 120,
  parameter int TRREFD      = 8,
  parameter int MAXPOSTPONE = 8,
  localparam int NBANKS     = 2**(BGWIDTH+BAWIDTH),
  localparam int OWEDW      = $clog2(MAXPOSTPONE+1)
) (
  input  logic               ck_t,
  input  logic               reset,
  input  logic               en,
  input  logic [NBANKS-1:0]  bank_idle,
  input  logic               ref_gnt,
  output logic               ref_req,
  output logic [BGWIDTH-1:0] ref_bg,
  output logic [BAWIDTH-1:0] ref_ba,
  output logic [NBANKS-1:0]  bank_busy,
  output logic               urgent,
  output logic [OWEDW-1:0]   owed,
  output logic               overflow
);

  localparam int PW = BGWIDTH + BAWIDTH;
  localparam int TW = $clog2(TREFI + 1);
  localparam int GW = $clog2(TRREFD + 1);
  localparam int CW = $clog2(TRFC + 1);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic            tick;
  logic [PW-1:0]   ptr;
  logic [GW-1:0]   gap;
  logic            grant;
  logic            sweep_done;
  logic [CW-1:0]   busy_cnt [NBANKS];

  // Handshake: ref_req is a valid that, once raised, holds its target until a cycle with
  // ref_req && ref_gnt; only that cycle transfers, and ref_gnt alone has no effect.
  assign grant      = ref_req && ref_gnt;
  assign sweep_done = grant && (&ptr);
  assign tick       = en && (timer == '0);
  assign {ref_bg, ref_ba} = ptr;
  assign urgent     = (owed >= OWEDW'(MAXPOSTPONE - 1));

  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      timer <= TW'(TREFI - 1);
    end else if (en) begin
      timer <= tick ? TW'(TREFI - 1) : timer - 1'b1;
    end
  end

  // A tick and a sweep completion in the same cycle cancel; debt never exceeds MAXPOSTPONE.
  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      owed     <= '0;
      overflow <= 1'b0;
    end else if (tick && !sweep_done) begin
      if (owed == OWEDW'(MAXPOSTPONE)) overflow <= 1'b1;
      else                             owed     <= owed + 1'b1;
    end else if (sweep_done && !tick) begin
      owed <= owed - 1'b1;
    end
  end

  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      gap   <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        ptr <= ptr + 1'b1;
        gap <= GW'(TRREFD);
      end else if (state == GAP && gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    ref_req    = 1'b0;
    case (state)
      IDLE: if (owed != '0 && en) state_next = REQ;
      REQ: begin
        // A blocked target stalls the sweep rather than being skipped.
        ref_req = bank_idle[ptr] && !bank_busy[ptr];
        if (ref_req && ref_gnt) state_next = GAP;
      end
      GAP: if (gap == GW'(1)) state_next = (owed != '0 && en) ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tRFC counters run independently of en so a granted bank always recovers.
  always_ff @(posedge ck_t or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NBANKS; b++) busy_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NBANKS; b++) begin
        if (grant && ptr == PW'(b))  busy_cnt[b] <= CW'(TRFC);
        else if (busy_cnt[b] != '0) busy_cnt[b] <= busy_cnt[b] - 1'b1;
      end
    end
  end

  always_comb begin
    bank_busy = '0;
    for (int b = 0; b < NBANKS; b++) bank_busy[b] = (busy_cnt[b] != '0);
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: checkpoint table of scenarios, a reset-mid-sweep sequence,
// and randomized traffic against a timestamp-based reference model.
module tb_refresh_scheduler;

  localparam int NB    = 16;
  localparam int TREFI = 20;
  localparam int TRFC  = 6;
  localparam int TRREFD = 2;
  localparam int MAXP  = 4;
  localparam int OW    = 3;

  logic          ck_t;
  logic          reset;
  logic          en;
  logic [NB-1:0] bank_idle;
  logic          ref_gnt;
  logic          ref_req;
  logic [1:0]    ref_bg;
  logic [1:0]    ref_ba;
  logic [NB-1:0] bank_busy;
  logic          urgent;
  logic [OW-1:0] owed;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  refresh_scheduler #(
    .BGWIDTH(2), .BAWIDTH(2), .TREFI(TREFI), .TRFC(TRFC),
    .TRREFD(TRREFD), .MAXPOSTPONE(MAXP)
  ) dut (
    .ck_t(ck_t), .reset(reset), .en(en), .bank_idle(bank_idle), .ref_gnt(ref_gnt),
    .ref_req(ref_req), .ref_bg(ref_bg), .ref_ba(ref_ba), .bank_busy(bank_busy),
    .urgent(urgent), .owed(owed), .overflow(overflow)
  );

  // clock / reset
  initial ck_t = 1'b0;
  always #5 ck_t = ~ck_t;

  // checkpoint table
  typedef struct {
    string       tag;
    bit          rst;
    int          n;
    bit          en;
    bit          gnt;
    logic [15:0] idle;
    bit          req;
    int          bg;
    int          ba;
    int          ow;
    bit          urg;
    bit          ovf;
    logic [15:0] busy;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input string tag, input bit rst, input int n, input bit e,
                              input bit g, input logic [15:0] idle, input bit req,
                              input int bg, input int ba, input int ow, input bit urg,
                              input bit ovf, input logic [15:0] busy);
    vec_t v;
    v.tag = tag; v.rst = rst; v.n = n; v.en = e; v.gnt = g; v.idle = idle;
    v.req = req; v.bg = bg; v.ba = ba; v.ow = ow; v.urg = urg; v.ovf = ovf; v.busy = busy;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit req, input int bg, input int ba,
                           input int ow, input bit urg, input bit ovf, input logic [15:0] busy);
    check({tag, ".req"},  32'(ref_req),   32'(req));
    check({tag, ".bg"},   32'(ref_bg),    32'(bg));
    check({tag, ".ba"},   32'(ref_ba),    32'(ba));
    check({tag, ".owed"}, 32'(owed),      32'(ow));
    check({tag, ".urg"},  32'(urgent),    32'(urg));
    check({tag, ".ovf"},  32'(overflow),  32'(ovf));
    check({tag, ".busy"}, 32'(bank_busy), 32'(busy));
  endtask

  // reference model: cycle timestamps instead of counters
  int  cyc, en_cnt, owed_m, grants, last_g;
  int  bank_last [NB];
  bit  ovf_m, open_m;
  logic [3:0] exp_q [$];

  function automatic void model_reset();
    cyc = 0; en_cnt = 0; owed_m = 0; grants = 0; last_g = -1000;
    ovf_m = 1'b0; open_m = 1'b0;
    for (int b = 0; b < NB; b++) bank_last[b] = -1000;
  endfunction

  function automatic bit model_busy(input int b);
    return (cyc - bank_last[b] >= 0) && (cyc - bank_last[b] < TRFC);
  endfunction

  function automatic bit model_req();
    int p;
    p = grants % NB;
    return open_m && bank_idle[p] && !model_busy(p);
  endfunction

  function automatic void model_step();
    int p;
    bit g, tk, done, open_n;
    p  = grants % NB;
    g  = model_req() && ref_gnt;
    tk = en && ((en_cnt + 1) % TREFI == 0);
    if (en) en_cnt++;
    done = g && (p == NB - 1);
    if (open_m) open_n = !g;
    else        open_n = (cyc >= last_g + TRREFD - 1) && (owed_m > 0) && en;
    if (tk && !done) begin
      if (owed_m == MAXP) ovf_m = 1'b1;
      else                owed_m++;
    end else if (done && !tk) begin
      owed_m--;
    end
    if (g) begin
      bank_last[p] = cyc + 1;
      last_g = cyc + 1;
      grants++;
      exp_q.push_back(4'(p));
    end
    open_m = open_n;
    cyc++;
  endfunction

  task automatic check_model();
    logic [15:0] busy_m;
    int p;
    p = grants % NB;
    busy_m = '0;
    for (int b = 0; b < NB; b++) busy_m[b] = model_busy(b);
    check("rnd.req",  32'(ref_req),   32'(model_req()));
    check("rnd.bg",   32'(ref_bg),    32'(p / 4));
    check("rnd.ba",   32'(ref_ba),    32'(p % 4));
    check("rnd.owed", 32'(owed),      32'(owed_m));
    check("rnd.urg",  32'(urgent),    32'(owed_m >= MAXP - 1));
    check("rnd.ovf",  32'(overflow),  32'(ovf_m));
    check("rnd.busy", 32'(bank_busy), 32'(busy_m));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; ref_gnt = 1'b0; bank_idle = '1;
    repeat (2) @(posedge ck_t);
    #1;

    // sweep with grant tied high; ticks land at en-cycles 20, 40, 60, ...
    add("t1_reset", 1, 0,  1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t1_e19",   0, 19, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t1_tick",  0, 1,  1, 1, 16'hFFFF, 0, 0, 0, 1, 0, 0, 16'h0000);
    add("t1_req0",  0, 1,  1, 1, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t1_gnt0",  0, 1,  1, 1, 16'hFFFF, 0, 0, 1, 1, 0, 0, 16'h0001);
    add("t1_req1",  0, 2,  1, 1, 16'hFFFF, 1, 0, 1, 1, 0, 0, 16'h0001);
    add("t1_e40",   0, 16, 1, 1, 16'hFFFF, 0, 1, 3, 2, 0, 0, 16'h0060);
    add("t1_e60",   0, 20, 1, 1, 16'hFFFF, 1, 3, 1, 3, 1, 0, 16'h1800);
    add("t1_e67",   0, 7,  1, 1, 16'hFFFF, 0, 0, 0, 2, 0, 0, 16'hC000);
    // bank 5 not idle stalls the sweep on bg1/ba1
    add("t2_blk",   0, 23, 1, 1, 16'hFFDF, 0, 1, 1, 3, 1, 0, 16'h0000);
    add("t2_hold",  0, 5,  1, 1, 16'hFFDF, 0, 1, 1, 3, 1, 0, 16'h0000);
    add("t2_rel",   0, 0,  1, 1, 16'hFFFF, 1, 1, 1, 3, 1, 0, 16'h0000);
    add("t2_gnt5",  0, 1,  1, 1, 16'hFFFF, 0, 1, 2, 3, 1, 0, 16'h0020);
    add("t2_b5end", 0, 5,  1, 1, 16'hFFFF, 1, 1, 3, 4, 1, 0, 16'h0060);
    add("t2_b5off", 0, 1,  1, 1, 16'hFFFF, 0, 2, 0, 4, 1, 0, 16'h00C0);
    // no grants: debt accumulates and saturates
    add("t3_reset", 1, 0,  1, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t3_o1",    0, 20, 1, 0, 16'hFFFF, 0, 0, 0, 1, 0, 0, 16'h0000);
    add("t3_req",   0, 1,  1, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t3_o2",    0, 19, 1, 0, 16'hFFFF, 1, 0, 0, 2, 0, 0, 16'h0000);
    add("t3_o3",    0, 20, 1, 0, 16'hFFFF, 1, 0, 0, 3, 1, 0, 16'h0000);
    add("t3_o4",    0, 20, 1, 0, 16'hFFFF, 1, 0, 0, 4, 1, 0, 16'h0000);
    add("t3_pre",   0, 19, 1, 0, 16'hFFFF, 1, 0, 0, 4, 1, 0, 16'h0000);
    add("t3_ovf",   0, 1,  1, 0, 16'hFFFF, 1, 0, 0, 4, 1, 1, 16'h0000);
    // en low for 10 cycles delays the tick; a pending request is still served with en low
    add("t4_run",    1, 5,  1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t4_en_off", 0, 10, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t4_e29",    0, 14, 1, 1, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0000);
    add("t4_tick",   0, 1,  1, 1, 16'hFFFF, 0, 0, 0, 1, 0, 0, 16'h0000);
    add("t4_req",    0, 1,  1, 1, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t4_hold",   0, 3,  0, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t4_gntin",  0, 0,  0, 1, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t4_gnt",    0, 1,  0, 1, 16'hFFFF, 0, 0, 1, 1, 0, 0, 16'h0001);
    add("t4_busy6",  0, 5,  0, 1, 16'hFFFF, 0, 0, 1, 1, 0, 0, 16'h0001);
    add("t4_idle",   0, 1,  0, 1, 16'hFFFF, 0, 0, 1, 1, 0, 0, 16'h0000);
    add("t4_resume", 0, 1,  1, 1, 16'hFFFF, 1, 0, 1, 1, 0, 0, 16'h0000);
    // last grant of a sweep coincides with a tick at en-cycle 80
    add("t6_wait",  1, 34, 1, 0, 16'hFFFF, 1, 0, 0, 1, 0, 0, 16'h0000);
    add("t6_pre",   0, 45, 1, 1, 16'hFFFF, 1, 3, 3, 3, 1, 0, 16'h6000);
    add("t6_coin",  0, 1,  1, 1, 16'hFFFF, 0, 0, 0, 3, 1, 0, 16'hC000);
    add("t6_gap",   0, 1,  1, 1, 16'hFFFF, 0, 0, 0, 3, 1, 0, 16'hC000);
    add("t6_next",  0, 1,  1, 1, 16'hFFFF, 1, 0, 0, 3, 1, 0, 16'hC000);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; ref_gnt = tbl[i].gnt; bank_idle = tbl[i].idle;
      if (tbl[i].rst) begin
        reset = 1'b1; #1; reset = 1'b0;
      end
      repeat (tbl[i].n) @(posedge ck_t);
      #1;
      check_all(tbl[i].tag, tbl[i].req, tbl[i].bg, tbl[i].ba, tbl[i].ow,
                tbl[i].urg, tbl[i].ovf, tbl[i].busy);
    end

    // reset in the middle of a sweep, while requesting bank 7
    en = 1'b1; ref_gnt = 1'b1; bank_idle = '1;
    reset = 1'b1; #1; reset = 1'b0;
    repeat (42) @(posedge ck_t);
    #1;
    check_all("t5_pre", 1, 1, 3, 2, 0, 0, 16'h0060);
    reset = 1'b1; #1;
    check_all("t5_rst", 0, 0, 0, 0, 0, 0, 16'h0000);
    reset = 1'b0;
    repeat (20) @(posedge ck_t);
    #1;
    check_all("t5_tick", 0, 0, 0, 1, 0, 0, 16'h0000);
    @(posedge ck_t);
    #1;
    check_all("t5_bank0", 1, 0, 0, 1, 0, 0, 16'h0000);

    // randomized traffic against the model, with rare asynchronous resets
    reset = 1'b1; #1; reset = 1'b0;
    model_reset();
    exp_q.delete();
    for (int i = 0; i < 2500; i++) begin
      en      = ($urandom_range(0, 9) != 0);
      ref_gnt = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < NB; b++) bank_idle[b] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1; #1; reset = 1'b0;
        model_reset();
        exp_q.delete();
      end
      #1;
      check_model();
      model_step();
      if (ref_req && ref_gnt) begin
        if (exp_q.size() == 0) check("rnd.grant_unexpected", 32'(1), 32'(0));
        else                   check("rnd.grant_bank", 32'({ref_bg, ref_ba}), 32'(exp_q.pop_front()));
      end
      @(posedge ck_t);
      #1;
    end
    check("rnd.grant_leftover", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
